// File: rtl/gun_position_ctrl.sv
// Gun aim point: joystick moves pos_h/pos_v on 4 ms ticks, vblank commits gun_h/gun_v.
// Define GUN_POSITION_CTRL_ACCEL_EN to enable the FAST state and hold counter.
module gun_position_ctrl #(
    parameter int H_MIN       = 0,
    parameter int H_MAX       = 63,
    parameter int V_MIN       = 0,
    parameter int V_MAX       = 63,
    parameter int ACCEL_TICKS = 16,
    parameter int STEP_FAST   = 2
) (
    input  logic       clock_12,
    input  logic       reset_n,
    input  logic       cnt_4ms,
    input  logic       video_vblank,
    input  logic       joy_right,
    input  logic       joy_left,
    input  logic       joy_down,
    input  logic       joy_up,
    input  logic       recentre,
    output logic [5:0] gun_h,
    output logic [5:0] gun_v
);

`ifdef GUN_POSITION_CTRL_ACCEL_EN
    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
    localparam logic [4:0] HOLD_LIM = 5'(ACCEL_TICKS - 1);
    localparam logic [6:0] STEP_HI  = 7'(STEP_FAST);
`else
    typedef enum logic {IDLE, SLOW} state_t;
    localparam int unused_accel = ACCEL_TICKS + STEP_FAST;
`endif

    // index 0 is the horizontal axis, index 1 the vertical axis
    localparam logic [1:0][6:0] LO  = {7'(V_MIN), 7'(H_MIN)};
    localparam logic [1:0][6:0] HI  = {7'(V_MAX), 7'(H_MAX)};
    localparam logic [1:0][5:0] CEN = {6'((V_MIN + V_MAX + 1) / 2),
                                       6'((H_MIN + H_MAX + 1) / 2)};

    logic            cnt_q, cnt_h, vb_q, vb_h;
    logic            tick, commit;
    logic [1:0]      fwd, bwd, mv, rev;
    state_t          st_q [2];
    state_t          st_d [2];
    logic [1:0]      dir_q, dir_d;
    logic [1:0][5:0] pos_q, pos_d;
    logic [1:0][6:0] step, inc;
    logic [1:0][5:0] dec;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
    logic [1:0][4:0] hold_q, hold_d, hold_inc;
`endif

    assign tick   = cnt_q & ~cnt_h;
    assign commit = vb_q & ~vb_h;
    assign fwd    = {joy_down, joy_right};
    assign bwd    = {joy_up, joy_left};
    assign mv     = fwd ^ bwd;
    assign rev[0] = (st_q[0] != IDLE) && (fwd[0] != dir_q[0]);
    assign rev[1] = (st_q[1] != IDLE) && (fwd[1] != dir_q[1]);
`ifdef GUN_POSITION_CTRL_ACCEL_EN
    assign hold_inc[0] = (hold_q[0] == 5'd31) ? hold_q[0] : hold_q[0] + 5'd1;
    assign hold_inc[1] = (hold_q[1] == 5'd31) ? hold_q[1] : hold_q[1] + 5'd1;
`endif

    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            cnt_q <= 1'b1;
            cnt_h <= 1'b1;
            vb_q  <= 1'b1;
            vb_h  <= 1'b1;
            dir_q <= '0;
            pos_q <= CEN;
            gun_h <= CEN[0];
            gun_v <= CEN[1];
            for (int a = 0; a < 2; a++) st_q[a] <= IDLE;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
            hold_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_4ms;
            cnt_h <= cnt_q;
            vb_q  <= video_vblank;
            vb_h  <= vb_q;
            dir_q <= dir_d;
            pos_q <= pos_d;
            for (int a = 0; a < 2; a++) st_q[a] <= st_d[a];
`ifdef GUN_POSITION_CTRL_ACCEL_EN
            hold_q <= hold_d;
`endif
            // pos_q here is the pre-tick value when tick and commit coincide
            if (commit) begin
                gun_h <= pos_q[0];
                gun_v <= pos_q[1];
            end
        end
    end

    always_comb begin
        dir_d = dir_q;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
        hold_d = hold_q;
`endif
        for (int a = 0; a < 2; a++) begin
            st_d[a] = st_q[a];
            if (recentre || (tick && !mv[a])) begin
                st_d[a] = IDLE;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
                hold_d[a] = '0;
`endif
            end else if (tick) begin
                dir_d[a] = fwd[a];
                if (st_q[a] == IDLE || rev[a]) begin
                    st_d[a] = SLOW;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
                    hold_d[a] = '0;
                end else begin
                    hold_d[a] = hold_inc[a];
                    if (hold_inc[a] >= HOLD_LIM) st_d[a] = FAST;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            step[a] = 7'd1;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
            if (st_q[a] == FAST && !rev[a]) step[a] = STEP_HI;
`endif
            inc[a]   = {1'b0, pos_q[a]} + step[a];
            dec[a]   = pos_q[a] - step[a][5:0];
            pos_d[a] = pos_q[a];
            if (recentre) begin
                pos_d[a] = CEN[a];
            end else if (tick && mv[a]) begin
                if (fwd[a])
                    pos_d[a] = (inc[a] > HI[a]) ? HI[a][5:0] : inc[a][5:0];
                else
                    pos_d[a] = ({1'b0, pos_q[a]} < LO[a] + step[a]) ?
                               LO[a][5:0] : dec[a];
            end
        end
    end

endmodule

// File: tb/tb_gun_position_ctrl.sv
// Directed bench for gun_position_ctrl: run-length motion model plus literal checks.
// Follows GUN_POSITION_CTRL_ACCEL_EN to choose the expected acceleration behaviour.
module tb_gun_position_ctrl;
    localparam int H_MIN       = 0;
    localparam int H_MAX       = 63;
    localparam int V_MIN       = 0;
    localparam int V_MAX       = 63;
    localparam int ACCEL_TICKS = 16;
    localparam int STEP_FAST   = 2;
`ifdef GUN_POSITION_CTRL_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic       clock_12     = 1'b0;
    logic       reset_n      = 1'b0;
    logic       cnt_4ms      = 1'b0;
    logic       video_vblank = 1'b0;
    logic       joy_right    = 1'b0;
    logic       joy_left     = 1'b0;
    logic       joy_down     = 1'b0;
    logic       joy_up       = 1'b0;
    logic       recentre     = 1'b0;
    logic [5:0] gun_h, gun_v;

    int checks   = 0;
    int failures = 0;
    int exp_h    = 32;
    int exp_v    = 32;
    bit cmp_en   = 1'b0;
    int mpos [2];
    int run  [2];
    bit mdir [2];

    gun_position_ctrl #(
        .H_MIN(H_MIN), .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX),
        .ACCEL_TICKS(ACCEL_TICKS), .STEP_FAST(STEP_FAST)
    ) dut (
        .clock_12(clock_12), .reset_n(reset_n), .cnt_4ms(cnt_4ms),
        .video_vblank(video_vblank), .joy_right(joy_right),
        .joy_left(joy_left), .joy_down(joy_down), .joy_up(joy_up),
        .recentre(recentre), .gun_h(gun_h), .gun_v(gun_v)
    );

    always #5 clock_12 = ~clock_12;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock_12) begin
        if (cmp_en) begin
            check("gun_h", int'(gun_h), exp_h);
            check("gun_v", int'(gun_v), exp_v);
        end
    end

    task automatic model_reset();
        mpos[0] = (H_MIN + H_MAX + 1) / 2;
        mpos[1] = (V_MIN + V_MAX + 1) / 2;
        for (int a = 0; a < 2; a++) begin
            run[a]  = 0;
            mdir[a] = 1'b0;
        end
    endtask

    // run[a] counts consecutive same-direction moving ticks; ticks past ACCEL_TICKS go fast
    task automatic model_tick();
        bit f [2];
        bit b [2];
        f[0] = joy_right; b[0] = joy_left;
        f[1] = joy_down;  b[1] = joy_up;
        for (int a = 0; a < 2; a++) begin
            int lo;
            int hi;
            int st;
            lo = (a == 0) ? H_MIN : V_MIN;
            hi = (a == 0) ? H_MAX : V_MAX;
            if (f[a] == b[a]) begin
                run[a] = 0;
            end else begin
                if (run[a] == 0 || mdir[a] != f[a]) run[a] = 1;
                else run[a]++;
                mdir[a] = f[a];
                st = (ACC && run[a] > ACCEL_TICKS) ? STEP_FAST : 1;
                if (f[a]) mpos[a] = (mpos[a] + st > hi) ? hi : mpos[a] + st;
                else      mpos[a] = (mpos[a] - st < lo) ? lo : mpos[a] - st;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock_12); #1 cnt_4ms = 1'b1;
        @(posedge clock_12); #1 cnt_4ms = 1'b0;
        model_tick();
        @(posedge clock_12); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic vblank(input bit with_tick);
        int sh;
        int sv;
        @(posedge clock_12); #1 video_vblank = 1'b1; cnt_4ms = with_tick;
        @(posedge clock_12); #1 video_vblank = 1'b0; cnt_4ms = 1'b0;
        sh = mpos[0];
        sv = mpos[1];
        if (with_tick) model_tick();
        @(posedge clock_12); #1 exp_h = sh; exp_v = sv;
        @(posedge clock_12); #1;
    endtask

    task automatic recentre_tick();
        @(posedge clock_12); #1 cnt_4ms = 1'b1;
        @(posedge clock_12); #1 recentre = 1'b1;
        @(posedge clock_12); #1 recentre = 1'b0; cnt_4ms = 1'b0;
        model_reset();
        @(posedge clock_12); #1;
    endtask

    initial begin
        model_reset();
        cnt_4ms = 1'b1; video_vblank = 1'b1; joy_right = 1'b1;
        @(posedge clock_12); #1 cmp_en = 1'b1;
        check("rst_gun_h", int'(gun_h), 32);
        check("rst_gun_v", int'(gun_v), 32);
        repeat (2) @(posedge clock_12);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock_12);
        #1 cnt_4ms = 1'b0; video_vblank = 1'b0; joy_right = 1'b0;
        vblank(1'b0);
        check("no_spurious_tick", int'(gun_h), 32);

        joy_right = 1'b1;
        ticks(5);
        check("pre_vblank_h", int'(gun_h), 32);
        vblank(1'b0);
        check("right5_h", int'(gun_h), 37);
        check("right5_v", int'(gun_v), 32);

        joy_right = 1'b0; joy_up = 1'b1;
        ticks(20);
        vblank(1'b0);
        check("up20_v", int'(gun_v), ACC ? 8 : 12);

        joy_up = 1'b0; joy_left = 1'b1;
        ticks(40);
        vblank(1'b0);
        check("left40_h", int'(gun_h), 0);
        ticks(3);
        vblank(1'b0);
        check("left_sat_h", int'(gun_h), 0);

        joy_right = 1'b1;
        ticks(3);
        vblank(1'b0);
        check("both_held_h", int'(gun_h), 0);

        joy_left = 1'b0;
        ticks(20);
        joy_right = 1'b0; joy_left = 1'b1;
        tick();
        vblank(1'b0);
        check("reverse_h", int'(gun_h), ACC ? 23 : 19);
        joy_right = 1'b1;
        ticks(3);
        joy_left = 1'b0;
        tick();
        vblank(1'b0);
        check("idle_restart_h", int'(gun_h), ACC ? 24 : 20);

        vblank(1'b1);
        check("coincide_old_h", int'(gun_h), ACC ? 24 : 20);
        vblank(1'b0);
        check("coincide_new_h", int'(gun_h), ACC ? 25 : 21);

        recentre_tick();
        for (int i = 0; i < 30 && mpos[0] != 50; i++) tick();
        vblank(1'b0);
        check("reach50_h", int'(gun_h), 50);
        recentre_tick();
        check("recentre_hold_h", int'(gun_h), 50);
        vblank(1'b0);
        check("recentre_h", int'(gun_h), 32);
        check("recentre_v", int'(gun_v), 32);

        ticks(20);
        vblank(1'b0);
        check("fast_run_h", int'(gun_h), ACC ? 56 : 52);
        @(posedge clock_12); #1 cnt_4ms = 1'b1;
        @(posedge clock_12); #1 reset_n = 1'b0;
        @(posedge clock_12); #1 cnt_4ms = 1'b0;
        model_reset();
        exp_h = 32; exp_v = 32;
        check("midrst_h", int'(gun_h), 32);
        check("midrst_v", int'(gun_v), 32);
        repeat (2) @(posedge clock_12);
        #1 reset_n = 1'b1;
        tick();
        vblank(1'b0);
        check("post_rst_h", int'(gun_h), 33);
        check("post_rst_v", int'(gun_v), 32);

        repeat (3) @(posedge clock_12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gun_position_ctrl.md
GUN_POSITION_CTRL -- requirements
Module: gun_position_ctrl

Interface
REQ-001 SHALL provide parameter H_MIN, default 0, left limit of gun_h.
REQ-002 SHALL provide parameter H_MAX, default 63, right limit of gun_h.
REQ-003 SHALL provide parameter V_MIN, default 0, top limit of gun_v.
REQ-004 SHALL provide parameter V_MAX, default 63, bottom limit of gun_v.
REQ-005 SHALL provide parameter ACCEL_TICKS, default 16, consecutive held ticks before fast motion.
REQ-006 SHALL provide parameter STEP_FAST, default 2, fast step size in counts per tick.
REQ-007 clock_12  in  1  system clock; every register is clocked on its rising edge.
REQ-008 reset_n  in  1  synchronous, active-low reset.
REQ-009 cnt_4ms  in  1  free-running 4 ms timebase level; each rising edge is one motion tick.
REQ-010 video_vblank  in  1  vertical blank; each rising edge is one frame commit point.
REQ-011 joy_right, joy_left, joy_down, joy_up  in  1 each  active-high direction requests.
REQ-012 recentre  in  1  level request to return the aim point to centre.
REQ-013 gun_h  out  6  committed horizontal gun position.
REQ-014 gun_v  out  6  committed vertical gun position.

Function
REQ-015 SHALL register cnt_4ms and video_vblank once each, and derive single-cycle tick and commit pulses from 0->1 transitions of the registered versions.
REQ-016 SHALL keep internal positions pos_h and pos_v, plus one state machine per axis with states IDLE, SLOW and FAST and a 5-bit hold counter.
REQ-017 On a tick with exactly one direction of an axis asserted, that axis SHALL move by 1 in SLOW or by STEP_FAST in FAST. Right and down increase the position; left and up decrease it.
REQ-018 On a tick with neither or both directions of an axis asserted, that axis SHALL hold its position, enter IDLE and clear its hold counter.
REQ-019 Transitions: IDLE->SLOW on the first moving tick; SLOW->FAST when the hold counter reaches ACCEL_TICKS-1 on a moving tick; a direction reversal on any tick goes to SLOW with the counter cleared.
REQ-020 The hold counter SHALL saturate and not wrap.
REQ-021 Arithmetic SHALL be done at 7 bits and saturate to [MIN, MAX]; the position never wraps, and a move that would overshoot lands exactly on the limit.
REQ-022 recentre high SHALL load pos_h=(H_MIN+H_MAX+1)/2 and pos_v=(V_MIN+V_MAX+1)/2 and force both axes to IDLE; it overrides a tick in the same cycle.
REQ-023 On a commit pulse, gun_h/gun_v SHALL load pos_h/pos_v in the next cycle. Outputs change only at commit, so latency from tick to output is up to one frame.
REQ-024 If tick and commit coincide, the outputs SHALL take the pre-tick pos values; the tick result is committed at the following vblank.
REQ-025 Joystick inputs SHALL be sampled only in tick cycles; changes between ticks have no effect.

Reset
REQ-026 While reset_n=0 at a clock edge: pos_h, pos_v, gun_h and gun_v SHALL equal their centre values (32/32 with default parameters).
REQ-027 While reset_n=0 at a clock edge: axis states SHALL be IDLE and hold counters 0.
REQ-028 While reset_n=0 at a clock edge: both edge-detect history registers SHALL be 1, so an input already high at release produces no spurious pulse.
REQ-029 Reset asserted mid-motion SHALL abandon the motion with no partial step; the first tick after release starts from IDLE at centre.

Configuration
REQ-030 Macro GUN_POSITION_CTRL_ACCEL_EN. When defined, FAST and the hold counter SHALL be implemented as described in REQ-016 to REQ-020. When undefined, the FAST state and the hold counter SHALL be absent, every moving tick SHALL step by 1, and ACCEL_TICKS and STEP_FAST SHALL be ignored.

Verification
REQ-031 Reset release, then joy_right held for 5 ticks, then one vblank edge -> gun_h=37, gun_v=32; before the vblank edge gun_h stays 32.
REQ-032 ACCEL_EN defined, joy_up held for 20 ticks, then vblank -> gun_v=32-16-2*4=8 (ticks 1-16 step 1, ticks 17-20 step 2).
REQ-033 joy_left held for 40 ticks from 32, then vblank -> gun_h=0 with no wrap; further ticks keep it at 0.
REQ-034 joy_right and joy_left both held for 3 ticks -> position unchanged and state IDLE; a right->left reversal in FAST -> next step is -1.
REQ-035 Tick and vblank edge in the same cycle after a +1 move -> gun_h shows the old value, and the new value appears at the next vblank.
REQ-036 recentre pulsed in the same cycle as a moving tick at gun_h=50 -> pos_h=32, committed at the next vblank; reset_n low mid-FAST -> outputs read 32/32 one cycle later.
